// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock generator: divides clk to a programmable SCLK rate,
// runs a counted N-bit burst in any CKP/CKE mode and emits shift/sample strobes.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             ckp,
  input  logic             cke,
  output logic             sclk,
  output logic             shift_stb,
  output logic             sample_stb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [DIV_W-1:0] hcnt, hcnt_n, div_q, div_qn;
  logic [CNT_W:0]   ecnt, ecnt_n, edge_k;
  logic [CNT_W-1:0] nbits_q, nbits_qn;
  logic             ckp_q, ckp_qn, cke_q, cke_qn;
  logic             sclk_n, shift_n, sample_n, busy_n, done_n;

  assign edge_k = ecnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      ecnt       <= '0;
      div_q      <= '0;
      nbits_q    <= '0;
      ckp_q      <= 1'b0;
      cke_q      <= 1'b0;
      sclk       <= 1'b0;
      shift_stb  <= 1'b0;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      hcnt       <= hcnt_n;
      ecnt       <= ecnt_n;
      div_q      <= div_qn;
      nbits_q    <= nbits_qn;
      ckp_q      <= ckp_qn;
      cke_q      <= cke_qn;
      sclk       <= sclk_n;
      shift_stb  <= shift_n;
      sample_stb <= sample_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    ecnt_n   = ecnt;
    div_qn   = div_q;
    nbits_qn = nbits_q;
    ckp_qn   = ckp_q;
    cke_qn   = cke_q;
    sclk_n   = sclk;
    shift_n  = 1'b0;
    sample_n = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        sclk_n = ckp;
        busy_n = 1'b0;
        if (start && !abort && nbits != '0) begin
          div_qn   = div;
          nbits_qn = nbits;
          ckp_qn   = ckp;
          cke_qn   = cke;
          hcnt_n   = div;
          ecnt_n   = '0;
          busy_n   = 1'b1;
          sclk_n   = ckp;
          state_n  = SETUP;
        end
      end
      SETUP, RUN: begin
        if (hcnt != '0) begin
          hcnt_n = hcnt - DIV_ONE;
        end else begin
          hcnt_n = div_q;
          sclk_n = ~sclk;
          ecnt_n = edge_k;
          // Odd edges lead (idle->active); CKE picks which edge shifts and which samples.
          if (edge_k[0]) begin
            shift_n  = ~cke_q;
            sample_n = cke_q;
          end else begin
            sample_n = ~cke_q;
            shift_n  = cke_q && (edge_k != {nbits_q, 1'b0});
          end
          state_n = (edge_k == {nbits_q, 1'b0}) ? HOLD : RUN;
        end
      end
      HOLD: begin
        if (hcnt != '0) begin
          hcnt_n = hcnt - DIV_ONE;
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ecnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides any edge or HOLD expiry in the same cycle.
    if (abort && state != IDLE) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      sclk_n   = ckp_q;
      shift_n  = 1'b0;
      sample_n = 1'b0;
      done_n   = 1'b0;
      hcnt_n   = '0;
      ecnt_n   = '0;
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: burst timing, strobe placement per mode,
// abort, ignored starts and asynchronous reset.
module tb_spi_sclk_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, ckp = 1'b1, cke = 1'b0;
  logic [7:0] div = 8'd0;
  logic [4:0] nbits = 5'd0;
  logic       sclk, shift_stb, sample_stb, busy, done;

  int tests = 0;
  int fails = 0;
  int edge_cyc[0:70];

  spi_sclk_gen #(.DIV_W(8), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .div(div),
    .nbits(nbits), .ckp(ckp), .cke(cke), .sclk(sclk), .shift_stb(shift_stb),
    .sample_stb(sample_stb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drives one burst (start seen at cycle 0) and records what the outputs did.
  // poke!=0: at that cycle re-issue start with different settings for one cycle.
  task automatic run_burst(input logic p_ckp, input logic p_cke, input logic [7:0] p_div,
                           input logic [4:0] p_n, input int poke,
                           output int r_busy1, output int r_done, output int r_edges,
                           output int r_sh_odd, output int r_sh_even, output int r_sa_odd,
                           output int r_sa_even, output int r_misalign,
                           output logic r_idle, output logic r_sclk_done);
    logic prev, is_edge;
    r_busy1 = -1; r_done = -1; r_edges = 0; r_sh_odd = 0; r_sh_even = 0;
    r_sa_odd = 0; r_sa_even = 0; r_misalign = 0; r_sclk_done = 1'bx;
    ckp = p_ckp; cke = p_cke; div = p_div; nbits = p_n;
    @(posedge clk); #1;
    r_idle = sclk;
    prev = sclk;
    start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (poke != 0 && c == poke) begin
        start = 1'b1; div = 8'd5; nbits = 5'd7; ckp = ~p_ckp; cke = ~p_cke;
      end
      if (poke != 0 && c == poke + 1) start = 1'b0;
      is_edge = (sclk !== prev);
      if (is_edge) begin
        r_edges++;
        if (r_edges < 70) edge_cyc[r_edges] = c;
      end
      if (shift_stb === 1'b1) begin
        if (!is_edge) r_misalign++;
        if (r_edges[0]) r_sh_odd++; else r_sh_even++;
      end
      if (sample_stb === 1'b1) begin
        if (!is_edge) r_misalign++;
        if (r_edges[0]) r_sa_odd++; else r_sa_even++;
      end
      if (busy === 1'b1 && r_busy1 < 0) r_busy1 = c;
      prev = sclk;
      if (done === 1'b1) begin
        r_done = c;
        r_sclk_done = sclk;
        if (busy !== 1'b0) r_misalign++;
        break;
      end
    end
    ckp = p_ckp; cke = p_cke;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({sclk, shift_stb, sample_stb, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=00000", {sclk, shift_stb, sample_stb, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (sclk !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_tracks_ckp sclk=%b busy=%b want sclk=1 busy=0", sclk, busy);
    end
  endtask

  task automatic test_t1_mode0;
    int b1, dn, ed, so, se, ao, ae, mis, bad;
    logic idl, sd;
    run_burst(1'b0, 1'b0, 8'd1, 5'd8, 0, b1, dn, ed, so, se, ao, ae, mis, idl, sd);
    bad = 0;
    for (int k = 1; k <= 16; k++) if (edge_cyc[k] != 1 + k * 2) bad++;
    tests++;
    if (b1 !== 1 || dn !== 35 || ed !== 16) begin
      fails++;
      $display("FAIL t1_timing busy@%0d done@%0d edges=%0d want 1/35/16", b1, dn, ed);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL t1_edge_cycles bad=%0d want 0 (first@%0d last@%0d)", bad, edge_cyc[1], edge_cyc[16]);
    end
    tests++;
    if (so !== 8 || se !== 0 || ae !== 8 || ao !== 0 || mis !== 0) begin
      fails++;
      $display("FAIL t1_strobes sh_odd=%0d sh_even=%0d sa_odd=%0d sa_even=%0d mis=%0d want 8/0/0/8/0",
               so, se, ao, ae, mis);
    end
    tests++;
    if (idl !== 1'b0 || sd !== 1'b0) begin
      fails++;
      $display("FAIL t1_idle_level before=%b after=%b want 0/0", idl, sd);
    end
  endtask

  task automatic test_t2_div0_mode3;
    int b1, dn, ed, so, se, ao, ae, mis;
    logic idl, sd;
    run_burst(1'b1, 1'b1, 8'd0, 5'd3, 0, b1, dn, ed, so, se, ao, ae, mis, idl, sd);
    tests++;
    if (dn !== 8 || ed !== 6 || edge_cyc[1] !== 2 || edge_cyc[6] !== 7) begin
      fails++;
      $display("FAIL t2_timing done@%0d edges=%0d first@%0d last@%0d want 8/6/2/7",
               dn, ed, edge_cyc[1], edge_cyc[6]);
    end
    tests++;
    if (ao !== 3 || se !== 2 || so !== 0 || ae !== 0 || mis !== 0) begin
      fails++;
      $display("FAIL t2_strobes sa_odd=%0d sh_even=%0d sh_odd=%0d sa_even=%0d mis=%0d want 3/2/0/0/0",
               ao, se, so, ae, mis);
    end
    tests++;
    if (idl !== 1'b1 || sd !== 1'b1) begin
      fails++;
      $display("FAIL t2_idle_level before=%b after=%b want 1/1", idl, sd);
    end
  endtask

  task automatic test_t3_modes;
    int b1, dn, ed, so, se, ao, ae, mis;
    logic idl, sd;
    for (int m = 0; m < 4; m++) begin
      logic p, e;
      p = m[1]; e = m[0];
      run_burst(p, e, 8'd3, 5'd5, 0, b1, dn, ed, so, se, ao, ae, mis, idl, sd);
      tests++;
      if (dn !== 45 || ed !== 10 || edge_cyc[2] - edge_cyc[1] !== 4 || edge_cyc[3] - edge_cyc[1] !== 8) begin
        fails++;
        $display("FAIL t3_timing mode=%0d done@%0d edges=%0d e1@%0d e2@%0d e3@%0d want 45/10/5/9/13",
                 m, dn, ed, edge_cyc[1], edge_cyc[2], edge_cyc[3]);
      end
      tests++;
      if (e ? (ao !== 5 || se !== 4 || so !== 0 || ae !== 0)
            : (so !== 5 || ae !== 5 || se !== 0 || ao !== 0) || mis !== 0) begin
        fails++;
        $display("FAIL t3_strobes mode=%0d sh_odd=%0d sh_even=%0d sa_odd=%0d sa_even=%0d mis=%0d",
                 m, so, se, ao, ae, mis);
      end
      tests++;
      if (idl !== p || sd !== p) begin
        fails++;
        $display("FAIL t3_idle_level mode=%0d before=%b after=%b want %b", m, idl, sd, p);
      end
    end
  endtask

  task automatic test_t4_abort;
    int extra;
    logic s4, sh4;
    extra = 0;
    ckp = 1'b1; cke = 1'b0; div = 8'd2; nbits = 5'd4;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 4) begin s4 = sclk; sh4 = shift_stb; end
      if (c == 6) abort = 1'b1;
      if (c == 7) begin
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || sclk !== 1'b1 || shift_stb !== 1'b0 || sample_stb !== 1'b0 || done !== 1'b0) begin
          fails++;
          $display("FAIL t4_abort_cycle busy=%b sclk=%b sh=%b sa=%b done=%b want 0/1/0/0/0",
                   busy, sclk, shift_stb, sample_stb, done);
        end
      end
      if (c > 7 && (busy !== 1'b0 || done !== 1'b0 || shift_stb !== 1'b0 ||
                    sample_stb !== 1'b0 || sclk !== 1'b1)) extra++;
    end
    tests++;
    if (s4 !== 1'b0 || sh4 !== 1'b1) begin
      fails++;
      $display("FAIL t4_first_edge sclk=%b shift=%b want 0/1", s4, sh4);
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL t4_after_abort activity=%0d want 0", extra);
    end
  endtask

  task automatic test_t5_ignored_start;
    int b1, dn, ed, so, se, ao, ae, mis, act;
    logic idl, sd;
    act = 0;
    ckp = 1'b0; cke = 1'b0; div = 8'd1; nbits = 5'd0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b0 || shift_stb !== 1'b0 || sample_stb !== 1'b0 || done !== 1'b0 || sclk !== 1'b0) act++;
    end
    tests++;
    if (act !== 0) begin
      fails++;
      $display("FAIL t5_nbits0 activity=%0d want 0", act);
    end
    run_burst(1'b0, 1'b0, 8'd1, 5'd2, 2, b1, dn, ed, so, se, ao, ae, mis, idl, sd);
    tests++;
    if (dn !== 11 || ed !== 4 || edge_cyc[1] !== 3 || edge_cyc[4] !== 9) begin
      fails++;
      $display("FAIL t5_busy_start done@%0d edges=%0d first@%0d last@%0d want 11/4/3/9",
               dn, ed, edge_cyc[1], edge_cyc[4]);
    end
    tests++;
    if (so !== 2 || ae !== 2 || se !== 0 || ao !== 0 || mis !== 0 || sd !== 1'b0) begin
      fails++;
      $display("FAIL t5_captured sh_odd=%0d sa_even=%0d sh_even=%0d sa_odd=%0d mis=%0d sclk_end=%b want 2/2/0/0/0/0",
               so, ae, se, ao, mis, sd);
    end
  endtask

  task automatic test_t6_async_reset;
    int b1, dn, ed, so, se, ao, ae, mis;
    logic idl, sd, bmid;
    ckp = 1'b1; cke = 1'b0; div = 8'd2; nbits = 5'd6;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bmid = busy;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bmid !== 1'b1 || {sclk, shift_stb, sample_stb, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL t6_async_reset busy_before=%b outs=%b want 1/00000", bmid,
               {sclk, shift_stb, sample_stb, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_burst(1'b1, 1'b0, 8'd2, 5'd6, 0, b1, dn, ed, so, se, ao, ae, mis, idl, sd);
    tests++;
    if (b1 !== 1 || dn !== 40 || ed !== 12 || so !== 6 || ae !== 6 || mis !== 0 || sd !== 1'b1) begin
      fails++;
      $display("FAIL t6_clean_burst busy@%0d done@%0d edges=%0d sh=%0d sa=%0d mis=%0d sclk_end=%b want 1/40/12/6/6/0/1",
               b1, dn, ed, so, ae, mis, sd);
    end
  endtask

  initial begin
    test_reset();
    test_t1_mode0();
    test_t2_div0_mode3();
    test_t3_modes();
    test_t4_abort();
    test_t5_ignored_start();
    test_t6_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
